// File: rtl/pipe_stage_pkg.sv
// Shared widths and constants for pipe_stage_reg instantiations, so every
// pipeline boundary pulls its field widths from one place.
package pipe_stage_pkg;

    localparam int CNT_W_DEF = 16;
    localparam logic [CNT_W_DEF-1:0] CNT_MAX = '1;

    localparam int PIPE_CTRL_W_DEF   = 8;
    localparam int PIPE_DATA_W_DEF   = 256;

    // Per-boundary field widths (control bits, then packed data payload).
    localparam int PIPE_CTRL_W_IFID  = 1;
    localparam int PIPE_DATA_W_IFID  = 64;
    localparam int PIPE_CTRL_W_IDEX  = 8;
    localparam int PIPE_DATA_W_IDEX  = 256;
    localparam int PIPE_CTRL_W_EXMEM = 6;
    localparam int PIPE_DATA_W_EXMEM = 160;
    localparam int PIPE_CTRL_W_MEMWB = 4;
    localparam int PIPE_DATA_W_MEMWB = 96;

endpackage

// File: rtl/pipe_skid_entry.sv
// One valid/ctrl/data holding entry. Priority: Reset > clear > load.
// The ctrl output reads zero whenever the entry is empty.
module pipe_skid_entry #(
    parameter int CTRL_W = 8,
    parameter int DATA_W = 256
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              clear,
    input  logic              load,
    input  logic [CTRL_W-1:0] load_ctrl,
    input  logic [DATA_W-1:0] load_data,
    output logic              valid,
    output logic [CTRL_W-1:0] ctrl,
    output logic [DATA_W-1:0] data
);

    logic [CTRL_W-1:0] ctrl_q;

    // NOTE: state uses <= so every flop samples pre-edge values; the wide data
    // register is reset too because OutData must read 0 after Reset.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            valid  <= 1'b0;
            ctrl_q <= '0;
            data   <= '0;
        end else if (clear) begin
            valid  <= 1'b0;
            ctrl_q <= '0;
        end else if (load) begin
            valid  <= 1'b1;
            ctrl_q <= load_ctrl;
            data   <= load_data;
        end
    end

    assign ctrl = valid ? ctrl_q : '0;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register with valid/ready, flush and stall counter.
// Define PIPE_STAGE_REG_SKID_EN to add a one-entry skid buffer (registered InReady).
module pipe_stage_reg
    import pipe_stage_pkg::*;
#(
    parameter int CTRL_W = PIPE_CTRL_W_DEF,
    parameter int DATA_W = PIPE_DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Flush,
    input  logic              InValid,
    output logic              InReady,
    input  logic [CTRL_W-1:0] InCtrl,
    input  logic [DATA_W-1:0] InData,
    output logic              OutValid,
    input  logic              OutReady,
    output logic [CTRL_W-1:0] OutCtrl,
    output logic [DATA_W-1:0] OutData,
    output logic [CNT_W-1:0]  StallCount
);

    localparam logic [CNT_W-1:0] SAT_MAX = '1;

    logic              main_valid;
    logic              main_load;
    logic              main_clear;
    logic [CTRL_W-1:0] load_ctrl;
    logic [DATA_W-1:0] load_data;
    logic              emit;
    logic              stall;

    assign emit  = main_valid && OutReady;
    assign stall = main_valid && !OutReady;

`ifdef PIPE_STAGE_REG_SKID_EN
    logic              skid_valid;
    logic              skid_load;
    logic              skid_clear;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;

    assign InReady = !skid_valid;

    // A parked skid word always drains into main before new input is taken.
    always_comb begin
        main_load  = 1'b0;
        main_clear = Flush;
        skid_load  = 1'b0;
        skid_clear = Flush;
        load_ctrl  = InCtrl;
        load_data  = InData;
        if (skid_valid) begin
            load_ctrl  = skid_ctrl;
            load_data  = skid_data;
            main_load  = emit;
            skid_clear = Flush || emit;
        end else if (InValid && !Flush) begin
            main_load = !main_valid || OutReady;
            skid_load = stall;
        end else begin
            main_clear = Flush || emit;
        end
    end

    pipe_skid_entry #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
        .Clk       (Clk),
        .Reset     (Reset),
        .clear     (skid_clear),
        .load      (skid_load),
        .load_ctrl (InCtrl),
        .load_data (InData),
        .valid     (skid_valid),
        .ctrl      (skid_ctrl),
        .data      (skid_data)
    );
`else
    logic accept;

    assign InReady    = !main_valid || OutReady;
    assign accept     = InValid && InReady && !Flush;
    assign main_load  = accept;
    assign main_clear = Flush || (emit && !accept);
    assign load_ctrl  = InCtrl;
    assign load_data  = InData;
`endif

    pipe_skid_entry #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
        .Clk       (Clk),
        .Reset     (Reset),
        .clear     (main_clear),
        .load      (main_load),
        .load_ctrl (load_ctrl),
        .load_data (load_data),
        .valid     (main_valid),
        .ctrl      (OutCtrl),
        .data      (OutData)
    );

    assign OutValid = main_valid;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            StallCount <= '0;
        end else if (stall && StallCount != SAT_MAX) begin
            StallCount <= StallCount + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg; a queue model of the stage contents
// supplies expectations. Works with or without PIPE_STAGE_REG_SKID_EN.
module tb_pipe_stage_reg;

    localparam int CW = 8;
    localparam int DW = 256;
`ifdef PIPE_STAGE_REG_SKID_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif

    typedef struct packed {
        logic [CW-1:0] ctrl;
        logic [DW-1:0] data;
    } word_t;

    logic          Clk = 1'b0;
    logic          Reset, Flush, InValid, OutReady;
    logic [CW-1:0] InCtrl;
    logic [DW-1:0] InData;
    logic          InReady, OutValid;
    logic [CW-1:0] OutCtrl;
    logic [DW-1:0] OutData;
    logic [15:0]   StallCount;
    logic          sat_in_ready, sat_out_valid;
    logic [CW-1:0] sat_out_ctrl;
    logic [DW-1:0] sat_out_data;
    logic [2:0]    sat_count;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: queue of words held by the stage, plus stall cycle tally.
    word_t         q[$];
    logic [DW-1:0] last_data = '0;
    int unsigned   stall_cycles = 0;
    logic          exp_ready, obs_ready;

    always #5 Clk = ~Clk;

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .CNT_W(16)) dut (
        .Clk(Clk), .Reset(Reset), .Flush(Flush), .InValid(InValid), .InReady(InReady),
        .InCtrl(InCtrl), .InData(InData), .OutValid(OutValid), .OutReady(OutReady),
        .OutCtrl(OutCtrl), .OutData(OutData), .StallCount(StallCount)
    );

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .CNT_W(3)) dut_sat (
        .Clk(Clk), .Reset(Reset), .Flush(Flush), .InValid(InValid), .InReady(sat_in_ready),
        .InCtrl(InCtrl), .InData(InData), .OutValid(sat_out_valid), .OutReady(OutReady),
        .OutCtrl(sat_out_ctrl), .OutData(sat_out_data), .StallCount(sat_count)
    );

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] d;
        for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    function automatic logic model_ready(input logic ordy);
        if (DEPTH == 1) return (q.size() == 0) || ordy;
        return q.size() < DEPTH;
    endfunction

    function automatic logic exp_valid();
        return q.size() != 0;
    endfunction

    function automatic logic [CW-1:0] exp_ctrl();
        return (q.size() != 0) ? q[0].ctrl : '0;
    endfunction

    function automatic logic [DW-1:0] exp_data();
        return (q.size() != 0) ? q[0].data : last_data;
    endfunction

    function automatic logic [15:0] exp_cnt16();
        return (stall_cycles > 65535) ? 16'hFFFF : 16'(stall_cycles);
    endfunction

    function automatic logic [2:0] exp_cnt3();
        return (stall_cycles > 7) ? 3'd7 : 3'(stall_cycles);
    endfunction

    // Drives one cycle of inputs, samples InReady before the edge, advances the model.
    task automatic drive(input logic rst, input logic fl, input logic iv,
                         input logic [CW-1:0] ic, input logic [DW-1:0] id, input logic ordy);
        word_t w;
        Reset = rst; Flush = fl; InValid = iv; InCtrl = ic; InData = id; OutReady = ordy;
        #1;
        obs_ready = InReady;
        exp_ready = model_ready(ordy);
        @(posedge Clk);
        if (rst) begin
            q.delete();
            stall_cycles = 0;
            last_data = '0;
        end else begin
            if (q.size() != 0 && !ordy) stall_cycles++;
            if (fl) begin
                q.delete();
            end else begin
                if (q.size() != 0 && ordy) void'(q.pop_front());
                if (iv && exp_ready) begin
                    w.ctrl = ic;
                    w.data = id;
                    q.push_back(w);
                end
            end
            if (q.size() != 0) last_data = q[0].data;
        end
        #1;
    endtask

    task automatic idle(input logic ordy);
        drive(1'b0, 1'b0, 1'b0, 8'h00, '0, ordy);
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b0, 1'b1, 8'h5A, rand_data(), 1'b0);
        drive(1'b1, 1'b1, 1'b1, 8'hC3, rand_data(), 1'b1);
        vectors++;
        if ({OutValid, OutCtrl, OutData, StallCount, sat_count} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: valid=%b ctrl=%h data=%h cnt=%h sat=%h, want all zero",
                     OutValid, OutCtrl, OutData, StallCount, sat_count);
        end
        Reset = 1'b0; Flush = 1'b0; InValid = 1'b0; OutReady = 1'b0;
        #1;
        vectors++;
        if (InReady !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_inready: got %b want 1", InReady);
        end
    endtask

    task automatic test_stream();
        logic [DW-1:0] d[4];
        for (int k = 0; k < 4; k++) d[k] = rand_data();
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 1'b0, 1'b1, 8'(k + 1), d[k], 1'b1);
            vectors++;
            if (OutValid !== 1'b1 || OutCtrl !== 8'(k + 1) || OutData !== d[k]) begin
                miscompares++;
                $display("FAIL stream_word%0d: valid=%b ctrl=%h data=%h want 1 %h %h",
                         k, OutValid, OutCtrl, OutData, 8'(k + 1), d[k]);
            end
        end
        idle(1'b1);
        vectors++;
        if (OutValid !== 1'b0 || OutCtrl !== 8'h00 || OutData !== d[3] || StallCount !== 16'd0) begin
            miscompares++;
            $display("FAIL stream_drain: valid=%b ctrl=%h cnt=%0d want 0 00 0 (data held)",
                     OutValid, OutCtrl, StallCount);
        end
    endtask

    task automatic test_stall();
        logic [DW-1:0] d;
        d = rand_data();
        drive(1'b0, 1'b0, 1'b1, 8'hA5, d, 1'b1);
        for (int k = 0; k < 5; k++) begin
            idle(1'b0);
            vectors++;
            if (OutValid !== 1'b1 || OutCtrl !== 8'hA5 || OutData !== d) begin
                miscompares++;
                $display("FAIL stall_hold%0d: valid=%b ctrl=%h want 1 a5", k, OutValid, OutCtrl);
            end
        end
        vectors++;
        if (StallCount !== 16'd5 || sat_count !== 3'd5) begin
            miscompares++;
            $display("FAIL stall_count: cnt=%0d sat=%0d want 5 5", StallCount, sat_count);
        end
        idle(1'b1);
        vectors++;
        if (OutValid !== 1'b0 || StallCount !== 16'd5) begin
            miscompares++;
            $display("FAIL stall_release: valid=%b cnt=%0d want 0 5", OutValid, StallCount);
        end
    endtask

    task automatic test_flush();
        logic [DW-1:0] d, dn;
        d  = rand_data();
        dn = rand_data();
        drive(1'b0, 1'b0, 1'b1, 8'hFF, d, 1'b1);
        drive(1'b0, 1'b1, 1'b1, 8'h77, rand_data(), 1'b0);
        vectors++;
        if (OutValid !== 1'b0 || OutCtrl !== 8'h00 || OutData !== d || StallCount !== 16'd6) begin
            miscompares++;
            $display("FAIL flush_kill: valid=%b ctrl=%h cnt=%0d want 0 00 6 (data held)",
                     OutValid, OutCtrl, StallCount);
        end
        drive(1'b0, 1'b0, 1'b1, 8'h3C, dn, 1'b1);
        vectors++;
        if (OutValid !== 1'b1 || OutCtrl !== 8'h3C || OutData !== dn) begin
            miscompares++;
            $display("FAIL flush_refill: valid=%b ctrl=%h want 1 3c", OutValid, OutCtrl);
        end
        idle(1'b1);
        vectors++;
        if (OutValid !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_dropped: valid=%b ctrl=%h want 0", OutValid, OutCtrl);
        end
    endtask

    task automatic test_saturate();
        drive(1'b0, 1'b0, 1'b1, 8'h42, rand_data(), 1'b1);
        for (int k = 0; k < 10; k++) idle(1'b0);
        vectors++;
        if (sat_count !== 3'd7 || StallCount !== 16'd16) begin
            miscompares++;
            $display("FAIL sat_count: sat=%0d cnt=%0d want 7 16", sat_count, StallCount);
        end
        drive(1'b0, 1'b1, 1'b0, 8'h00, '0, 1'b1);
        idle(1'b1);
        vectors++;
        if (sat_count !== 3'd7 || StallCount !== 16'd16) begin
            miscompares++;
            $display("FAIL sat_after_flush: sat=%0d cnt=%0d want 7 16", sat_count, StallCount);
        end
    endtask

    task automatic test_reset_mid_stall();
        drive(1'b0, 1'b0, 1'b1, 8'h99, rand_data(), 1'b1);
        idle(1'b0);
        idle(1'b0);
        drive(1'b1, 1'b1, 1'b1, 8'h11, rand_data(), 1'b0);
        vectors++;
        if ({OutValid, OutCtrl, OutData, StallCount, sat_count} !== '0) begin
            miscompares++;
            $display("FAIL reset_mid_stall: valid=%b ctrl=%h cnt=%0d sat=%0d want all zero",
                     OutValid, OutCtrl, StallCount, sat_count);
        end
        Reset = 1'b0; Flush = 1'b0; InValid = 1'b0;
        #1;
        vectors++;
        if (InReady !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_mid_stall_inready: got %b want 1", InReady);
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] da, db, dc;
        da = rand_data(); db = rand_data(); dc = rand_data();
        drive(1'b0, 1'b0, 1'b1, 8'h0A, da, 1'b1);
        // OutReady drops in the same cycle B is offered.
        drive(1'b0, 1'b0, 1'b1, 8'h0B, db, 1'b0);
        Reset = 1'b0; InValid = 1'b0; OutReady = 1'b0;
        #1;
        vectors++;
        if (InReady !== ((DEPTH == 2) ? 1'b0 : 1'b0) || OutCtrl !== 8'h0A) begin
            miscompares++;
            $display("FAIL b2b_backpressure: inready=%b ctrl=%h want 0 0a", InReady, OutCtrl);
        end
        if (DEPTH == 1) drive(1'b0, 1'b0, 1'b1, 8'h0B, db, 1'b1);
        else            drive(1'b0, 1'b0, 1'b1, 8'h0C, dc, 1'b1);
        vectors++;
        if (OutValid !== 1'b1 || OutCtrl !== 8'h0B || OutData !== db) begin
            miscompares++;
            $display("FAIL b2b_second: valid=%b ctrl=%h want 1 0b", OutValid, OutCtrl);
        end
        drive(1'b0, 1'b0, 1'b1, 8'h0C, dc, 1'b1);
        vectors++;
        if (OutValid !== 1'b1 || OutCtrl !== 8'h0C || OutData !== dc) begin
            miscompares++;
            $display("FAIL b2b_third: valid=%b ctrl=%h want 1 0c", OutValid, OutCtrl);
        end
        idle(1'b1);
        vectors++;
        if (OutValid !== 1'b0 || q.size() != 0) begin
            miscompares++;
            $display("FAIL b2b_drain: valid=%b want 0 (no duplicate)", OutValid);
        end
    endtask

    task automatic test_random();
        logic rst, fl, iv, ordy;
        for (int n = 0; n < 600; n++) begin
            rst  = ($urandom_range(63) == 0);
            fl   = ($urandom_range(15) == 0);
            iv   = ($urandom_range(9) < 6);
            ordy = ($urandom_range(9) < 6);
            drive(rst, fl, iv, 8'($urandom), rand_data(), ordy);
            vectors++;
            if (obs_ready !== exp_ready) begin
                miscompares++;
                $display("FAIL rand_inready@%0d: got %b want %b", n, obs_ready, exp_ready);
            end
            vectors++;
            if ({OutValid, OutCtrl, OutData, StallCount, sat_count} !==
                {exp_valid(), exp_ctrl(), exp_data(), exp_cnt16(), exp_cnt3()}) begin
                miscompares++;
                $display("FAIL rand_out@%0d: valid=%b ctrl=%h cnt=%0d sat=%0d data=%h want %b %h %0d %0d %h",
                         n, OutValid, OutCtrl, StallCount, sat_count, OutData,
                         exp_valid(), exp_ctrl(), exp_cnt16(), exp_cnt3(), exp_data());
            end
            vectors++;
            if ({sat_out_valid, sat_out_ctrl, sat_out_data} !== {OutValid, OutCtrl, OutData}
                || sat_in_ready !== InReady) begin
                miscompares++;
                $display("FAIL rand_sat_instance@%0d: valid=%b ctrl=%h want %b %h",
                         n, sat_out_valid, sat_out_ctrl, OutValid, OutCtrl);
            end
        end
    endtask

    initial begin
        Reset = 1'b1; Flush = 1'b0; InValid = 1'b0; OutReady = 1'b0;
        InCtrl = '0; InData = '0;
        test_reset();
        test_stream();
        test_stall();
        test_flush();
        test_saturate();
        test_reset_mid_stall();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Generic, parametrised pipeline stage register that replaces the hand-written per-stage latches (IF/ID … MEM/WB) with one block. It carries a control field and a data field, adds a valid/ready handshake with stall and flush, forces control bits to zero on bubbles, and counts back-pressure cycles. It sits between any two datapath stages of the processor.

## Interface
- CTRL_W, 8: control-field width (RegWrite, MemToReg, SAD, HiLoWrite, …); zeroed on every bubble.
- DATA_W, 256: data-field width (PC+4, ALU result, operands, SAD operands, …).
- CNT_W, 16: stall-counter width.
- Reset is synchronous and active-high; clock is Clk.
- Clk  in  1  clock, all state on rising edge
- Reset  in  1  synchronous, active-high
- Flush  in  1  kill stage contents (branch/jump squash)
- InValid  in  1  upstream holds a valid word
- InReady  out  1  stage can accept this cycle
- InCtrl  in  CTRL_W  upstream control field
- InData  in  DATA_W  upstream data field
- OutValid  out  1  stage holds a valid word
- OutReady  in  1  downstream accepts this cycle
- OutCtrl  out  CTRL_W  control field; 0 whenever OutValid=0
- OutData  out  DATA_W  data field
- StallCount  out  CNT_W  saturating count of cycles with OutValid=1, OutReady=0

## Operation
- Accept: InValid && InReady at a rising edge. Emit: OutValid && OutReady at a rising edge.
- Main register holds valid, ctrl, data. On accept without stall, the word is loaded and presented the next cycle.
- Bubble: when OutValid=0, OutCtrl reads 0 regardless of stored ctrl; OutData holds its last value (not cleared).
- Stall: OutValid=1 && OutReady=0 → main register holds; StallCount increments, saturating at 2^CNT_W−1.
- Flush: at the edge, valid clears in all entries, stored ctrl clears, data retained; any word offered upstream in that cycle is dropped even if InReady=1. StallCount unaffected.
- Reset: overrides Flush and all handshakes. OutValid=0, OutCtrl=0, OutData=0, StallCount=0, skid empty, InReady=1 in the cycle after Reset deasserts.
- Simultaneous accept and emit on a full main register: new word replaces old, no bubble.

## Timing
- Latency InValid→OutValid: 1 cycle. Throughput: 1 word/cycle with OutReady held high.
- Without skid: InReady = !OutValid || OutReady (combinational path OutReady→InReady).
- With skid: InReady is a register output; no combinational input→output path.
- Flush asserted in cycle n → OutValid=0 from cycle n+1; first new word visible at n+2 earliest.
- StallCount updates at the edge ending each stall cycle; visible the following cycle.

## Configuration
- Macro PIPE_STAGE_REG_SKID_EN.
- Defined: adds a one-entry skid buffer behind the main register. InReady = skid empty (registered). When OutReady drops while a word arrives, it lands in skid; skid drains into main on the next emit before new input is taken. Order preserved. Flush/Reset empty both entries.
- Undefined: single register, combinational InReady as above; no skid storage synthesised.

## Structure
- Shared package pipe_stage_pkg: default CNT_W, CNT_MAX constant, stage-field width constants (PIPE_CTRL_W_MEMWB, PIPE_DATA_W_MEMWB, etc.) so each instantiation pulls widths from one place.
- Sub-module pipe_skid_entry: one valid/ctrl/data holding entry with load, clear and ctrl-zeroing; instantiated once as main, once more as skid under PIPE_STAGE_REG_SKID_EN.

## Test plan
- Reset then stream 4 words ctrl=0x01..0x04, OutReady=1 → outputs appear one cycle later, back-to-back, order intact; StallCount=0.
- Hold OutReady=0 for 5 cycles with word ctrl=0xA5 present → OutCtrl/OutData stable, StallCount=5; release → word emitted once.
- Flush while stage holds ctrl=0xFF, InValid=1 same cycle → next cycle OutValid=0, OutCtrl=0, dropped input never appears.
- CNT_W=3, 10 stall cycles → StallCount saturates at 7; Flush does not clear it, Reset does.
- Skid build: drop OutReady in same cycle as accept → InReady=0 next cycle, both words delivered in order after OutReady=1, no loss/duplication.
- Reset asserted mid-stall with Flush=1 → all outputs 0 next cycle, InReady=1 after Reset deasserts.
